id_imm_ctrl: RTL and testbench
==============================

ID_IMM_CTRL -- requirements
Module: id_imm_ctrl

Interface
REQ-001 SHALL have parameter EXTOP_W, default 6, width of the ext_op code.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port flush  input  1  synchronous discard of all buffered entries.
REQ-005 SHALL have ports in_valid  input  1, in_ready  output  1  upstream (IF) handshake.
REQ-006 SHALL have ports in_instr  input  32, in_pc  input  32  fetched instruction and its PC.
REQ-007 SHALL have ports out_valid  output  1, out_ready  input  1  downstream (EX) handshake.
REQ-008 SHALL have ports out_pc  output  32, out_imm  output  32, out_ext_op  output  EXTOP_W, out_illegal  output  1  head-entry payload.

Function
REQ-009 SHALL use one-hot ext_op codes: SHAMT 000001, ITYPE 000010, STYPE 000100, BTYPE 001000, UTYPE 010000, JTYPE 100000, NONE 000000.
REQ-010 SHALL select ext_op from opcode in_instr[6:0]: 0010011 with funct3 001/101 -> SHAMT, otherwise -> ITYPE; 0000011, 1100111, 1110011 -> ITYPE; 0100011 -> STYPE; 1100011 -> BTYPE; 0110111, 0010111 -> UTYPE; 1101111 -> JTYPE; 0110011, 0001111 -> NONE.
REQ-011 SHALL flag illegal (ext_op NONE, imm 0) for any other opcode, or any instr[1:0] != 11.
REQ-012 SHALL compute the immediate combinationally at accept time: SHAMT {27'b0, instr[24:20]}; ITYPE sext(instr[31:20]); STYPE sext({instr[31:25], instr[11:7]}); BTYPE sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}); UTYPE {instr[31:12], 12'b0}; JTYPE sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}); NONE 0.
REQ-013 SHALL store {pc, imm, ext_op, illegal} per entry in a 2-entry skid buffer (head, tail).
REQ-014 SHALL track occupancy with FSM states EMPTY, ONE, TWO; push = in_valid & in_ready; pop = out_valid & out_ready.
REQ-015 SHALL drive in_ready = (state != TWO) and out_valid = (state != EMPTY), both from registered state only.
REQ-016 SHALL transition EMPTY -> ONE on push (entry to head); otherwise stay.
REQ-017 SHALL in ONE: push & !pop -> TWO (entry to tail); pop & !push -> EMPTY; push & pop -> ONE with new entry as head.
REQ-018 SHALL in TWO: pop -> ONE with tail moved to head; no pop -> stay; push impossible (in_ready low).
REQ-019 SHALL have latency 1 cycle: an instruction accepted at edge N appears on out_* after edge N when buffer was EMPTY.
REQ-020 SHALL hold out_* stable while out_valid & !out_ready.
REQ-021 SHALL preserve acceptance order; no entry dropped or duplicated except by flush/rst.
REQ-022 SHALL on flush go to EMPTY next cycle, discarding head, tail and any same-cycle push; a same-cycle pop completes normally downstream.
REQ-023 SHALL give rst priority over flush, and flush priority over push/pop.
REQ-024 SHALL accept new push in the cycle after flush (in_ready = 1).

Reset
REQ-025 SHALL on rst: state EMPTY, out_valid 0, in_ready 1 after the edge; out_pc, out_imm 0, out_ext_op 0, out_illegal 0; tail entry cleared.
REQ-026 SHALL treat rst asserted mid-transfer as discarding all entries with no output pulse after the edge.

Verification
REQ-027 SHALL check: push 0xFFF00093 (addi x1,x0,-1) pc 0x100, out_ready=1 -> next cycle out_valid=1, out_imm 0xFFFFFFFF, out_ext_op 000010, out_pc 0x100.
REQ-028 SHALL check: push 0x00509093 (slli) then 0xFE000EE3 (beq -4) back-to-back, out_ready=0 -> state TWO, in_ready=0; then out_ready=1 -> imm 0x00000005/SHAMT then 0xFFFFFFFC/BTYPE in order.
REQ-029 SHALL check: push 0x123450B7 (lui) and 0xFF9FF06F (jal -8) -> imm 0x12345000/UTYPE and 0xFFFFFFF8/JTYPE.
REQ-030 SHALL check: push 0x0000007F -> out_illegal=1, out_ext_op 0, out_imm 0.
REQ-031 SHALL check: state TWO, flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, flushed and pushed entries never appear.
REQ-032 SHALL check: state ONE, simultaneous push & pop for 8 cycles -> one output per cycle, order preserved, state remains ONE.

Source files
------------

// File: rtl/id_imm_ctrl.sv
// Decode-stage immediate extractor feeding a 2-entry skid buffer between IF and EX.
// Each accepted instruction is stored as {pc, imm, ext_op, illegal} and presented in order.
module id_imm_ctrl #(
    parameter int EXTOP_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_instr,
    input  logic [31:0]        in_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_pc,
    output logic [31:0]        out_imm,
    output logic [EXTOP_W-1:0] out_ext_op,
    output logic               out_illegal
);

    localparam logic [EXTOP_W-1:0] EXT_NONE  = EXTOP_W'(6'b000000);
    localparam logic [EXTOP_W-1:0] EXT_SHAMT = EXTOP_W'(6'b000001);
    localparam logic [EXTOP_W-1:0] EXT_ITYPE = EXTOP_W'(6'b000010);
    localparam logic [EXTOP_W-1:0] EXT_STYPE = EXTOP_W'(6'b000100);
    localparam logic [EXTOP_W-1:0] EXT_BTYPE = EXTOP_W'(6'b001000);
    localparam logic [EXTOP_W-1:0] EXT_UTYPE = EXTOP_W'(6'b010000);
    localparam logic [EXTOP_W-1:0] EXT_JTYPE = EXTOP_W'(6'b100000);

    typedef struct packed {
        logic [31:0]        pc;
        logic [31:0]        imm;
        logic [EXTOP_W-1:0] ext_op;
        logic               illegal;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        TWO
    } state_t;

    state_t state, state_next;
    entry_t head, tail, new_entry, head_d;
    logic   load_head, load_tail;
    logic   push, pop;

    logic [6:0] opcode;
    logic [2:0] funct3;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];

    // Decode the format, then build the immediate for that format.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        new_entry         = '0;
        new_entry.pc      = in_pc;
        new_entry.ext_op  = EXT_NONE;
        new_entry.illegal = 1'b0;
        if (in_instr[1:0] != 2'b11) begin
            new_entry.illegal = 1'b1;
        end else begin
            case (opcode)
                7'b0010011: new_entry.ext_op = (funct3 == 3'b001 || funct3 == 3'b101) ? EXT_SHAMT : EXT_ITYPE;
                7'b0000011,
                7'b1100111,
                7'b1110011: new_entry.ext_op = EXT_ITYPE;
                7'b0100011: new_entry.ext_op = EXT_STYPE;
                7'b1100011: new_entry.ext_op = EXT_BTYPE;
                7'b0110111,
                7'b0010111: new_entry.ext_op = EXT_UTYPE;
                7'b1101111: new_entry.ext_op = EXT_JTYPE;
                7'b0110011,
                7'b0001111: new_entry.ext_op = EXT_NONE;
                default:    new_entry.illegal = 1'b1;
            endcase
        end

        case (new_entry.ext_op)
            EXT_SHAMT: new_entry.imm = {27'b0, in_instr[24:20]};
            EXT_ITYPE: new_entry.imm = {{20{in_instr[31]}}, in_instr[31:20]};
            EXT_STYPE: new_entry.imm = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            EXT_BTYPE: new_entry.imm = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                                        in_instr[30:25], in_instr[11:8], 1'b0};
            EXT_UTYPE: new_entry.imm = {in_instr[31:12], 12'b0};
            EXT_JTYPE: new_entry.imm = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                                        in_instr[20], in_instr[30:21], 1'b0};
            default:   new_entry.imm = '0;
        endcase
    end

    assign in_ready  = (state != TWO);
    assign out_valid = (state != EMPTY);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Flush overrides any push/pop; a pop in the same cycle is still seen downstream.
    always_comb begin
        state_next = state;
        load_head  = 1'b0;
        load_tail  = 1'b0;
        head_d     = new_entry;
        if (flush) begin
            state_next = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (push) begin
                        state_next = ONE;
                        load_head  = 1'b1;
                    end
                end
                ONE: begin
                    if (push && !pop) begin
                        state_next = TWO;
                        load_tail  = 1'b1;
                    end else if (pop && !push) begin
                        state_next = EMPTY;
                    end else if (push && pop) begin
                        load_head = 1'b1;
                    end
                end
                TWO: begin
                    if (pop) begin
                        state_next = ONE;
                        load_head  = 1'b1;
                        head_d     = tail;
                    end
                end
                default: state_next = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: the payload registers are reset too, because the head drives out_* directly and must read zero after reset.
        if (rst) begin
            state <= EMPTY;
            head  <= '0;
            tail  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state <= state_next;
            if (load_head) head <= head_d;
            if (load_tail) tail <= new_entry;
        end
    end

    assign out_pc      = head.pc;
    assign out_imm     = head.imm;
    assign out_ext_op  = head.ext_op;
    assign out_illegal = head.illegal;

endmodule

// File: tb/tb_id_imm_ctrl.sv
// Self-checking bench for id_imm_ctrl: vector table, directed buffer corner cases,
// and randomized traffic against a queue-based reference model.
module tb_id_imm_ctrl;

    localparam logic [5:0] SH = 6'b000001;
    localparam logic [5:0] IT = 6'b000010;
    localparam logic [5:0] ST = 6'b000100;
    localparam logic [5:0] BT = 6'b001000;
    localparam logic [5:0] UT = 6'b010000;
    localparam logic [5:0] JT = 6'b100000;
    localparam logic [5:0] NO = 6'b000000;

    logic        clk, rst, flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
    logic [31:0] in_instr, in_pc, out_pc, out_imm;
    logic [5:0]  out_ext_op;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] imm;
        logic [5:0]  ext;
        logic        ill;
    } ent_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [5:0]  ext;
        logic        ill;
    } vec_t;

    ent_t model_q[$];
    vec_t vecs[14];

    id_imm_ctrl #(.EXTOP_W(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .in_pc      (in_pc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_pc     (out_pc),
        .out_imm    (out_imm),
        .out_ext_op (out_ext_op),
        .out_illegal(out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic int sext(input int v, input int bits);
        return (v >= (1 << (bits - 1))) ? v - (1 << bits) : v;
    endfunction

    // Reference decode written straight from the field layouts with integer arithmetic.
    function automatic ent_t ref_decode(input logic [31:0] instr, input logic [31:0] pc);
        ent_t e;
        int   f3;
        e.pc  = pc;
        e.imm = 0;
        e.ext = NO;
        e.ill = 1'b0;
        f3    = int'(instr[14:12]);
        if (instr[1:0] != 2'b11) begin
            e.ill = 1'b1;
        end else begin
            case (instr[6:0])
                7'h13: begin
                    if (f3 == 1 || f3 == 5) begin
                        e.ext = SH;
                        e.imm = int'(instr[24:20]);
                    end else begin
                        e.ext = IT;
                        e.imm = sext(int'(instr[31:20]), 12);
                    end
                end
                7'h03, 7'h67, 7'h73: begin
                    e.ext = IT;
                    e.imm = sext(int'(instr[31:20]), 12);
                end
                7'h23: begin
                    e.ext = ST;
                    e.imm = sext(int'(instr[31:25]) * 32 + int'(instr[11:7]), 12);
                end
                7'h63: begin
                    e.ext = BT;
                    e.imm = sext(int'(instr[31]) * 4096 + int'(instr[7]) * 2048
                                 + int'(instr[30:25]) * 32 + int'(instr[11:8]) * 2, 13);
                end
                7'h37, 7'h17: begin
                    e.ext = UT;
                    e.imm = instr & 32'hFFFF_F000;
                end
                7'h6F: begin
                    e.ext = JT;
                    e.imm = sext(int'(instr[31]) * (1 << 20) + int'(instr[19:12]) * (1 << 12)
                                 + int'(instr[20]) * (1 << 11) + int'(instr[30:21]) * 2, 21);
                end
                7'h33, 7'h0F: e.ext = NO;
                default:      e.ill = 1'b1;
            endcase
        end
        return e;
    endfunction

    // One clock: drive at negedge, advance the model, compare 1 ns after the rising edge.
    task automatic cycle(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                         input logic rdy, input logic fl, input logic r);
        logic do_push, do_pop;
        @(negedge clk);
        in_valid  = v;
        in_instr  = instr;
        in_pc     = pc;
        out_ready = rdy;
        flush     = fl;
        rst       = r;
        do_push   = v && (model_q.size() < 2);
        do_pop    = rdy && (model_q.size() > 0);
        if (r || fl) begin
            model_q.delete();
        end else begin
            if (do_pop) void'(model_q.pop_front());
            if (do_push) model_q.push_back(ref_decode(instr, pc));
        end
        @(posedge clk);
        #1;
        check("m_in_ready", 32'(in_ready), 32'(model_q.size() < 2));
        check("m_out_valid", 32'(out_valid), 32'(model_q.size() > 0));
        if (model_q.size() > 0) begin
            check("m_out_pc", out_pc, model_q[0].pc);
            check("m_out_imm", out_imm, model_q[0].imm);
            check("m_out_ext_op", 32'(out_ext_op), 32'(model_q[0].ext));
            check("m_out_illegal", 32'(out_illegal), 32'(model_q[0].ill));
        end
    endtask

    task automatic idle(input logic rdy);
        cycle(1'b0, 32'h0, 32'h0, rdy, 1'b0, 1'b0);
    endtask

    initial begin
        logic [6:0]  ops[13];
        logic [31:0] r32, instr;

        vecs[0]  = '{32'hFFF00093, 32'h100, 32'hFFFFFFFF, IT, 1'b0};
        vecs[1]  = '{32'h00509093, 32'h104, 32'h00000005, SH, 1'b0};
        vecs[2]  = '{32'hFE000EE3, 32'h108, 32'hFFFFFFFC, BT, 1'b0};
        vecs[3]  = '{32'h123450B7, 32'h10C, 32'h12345000, UT, 1'b0};
        vecs[4]  = '{32'hFF9FF06F, 32'h110, 32'hFFFFFFF8, JT, 1'b0};
        vecs[5]  = '{32'h0000007F, 32'h114, 32'h00000000, NO, 1'b1};
        vecs[6]  = '{32'h4020D093, 32'h118, 32'h00000002, SH, 1'b0};
        vecs[7]  = '{32'h00812083, 32'h11C, 32'h00000008, IT, 1'b0};
        vecs[8]  = '{32'hFE112E23, 32'h120, 32'hFFFFFFFC, ST, 1'b0};
        vecs[9]  = '{32'h003100B3, 32'h124, 32'h00000000, NO, 1'b0};
        vecs[10] = '{32'h00000012, 32'h128, 32'h00000000, NO, 1'b1};
        vecs[11] = '{32'h00001097, 32'h12C, 32'h00001000, UT, 1'b0};
        vecs[12] = '{32'h0000000F, 32'h130, 32'h00000000, NO, 1'b0};
        vecs[13] = '{32'h00000073, 32'h134, 32'h00000000, IT, 1'b0};
        ops = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37,
                7'h17, 7'h6F, 7'h33, 7'h0F, 7'h7F, 7'h5B};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_pc = '0;

        // Reset state
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_pc", out_pc, 32'd0);
        check("rst_out_imm", out_imm, 32'd0);
        check("rst_out_ext_op", 32'(out_ext_op), 32'd0);
        check("rst_out_illegal", 32'(out_illegal), 32'd0);

        // Vector table: one push from EMPTY, visible right after the edge, then drained
        foreach (vecs[i]) begin
            cycle(1'b1, vecs[i].instr, vecs[i].pc, 1'b1, 1'b0, 1'b0);
            check("vec_valid", 32'(out_valid), 32'd1);
            check("vec_pc", out_pc, vecs[i].pc);
            check("vec_imm", out_imm, vecs[i].imm);
            check("vec_ext_op", 32'(out_ext_op), 32'(vecs[i].ext));
            check("vec_illegal", 32'(out_illegal), 32'(vecs[i].ill));
            idle(1'b1);
            check("vec_drained", 32'(out_valid), 32'd0);
        end

        // Two back-to-back pushes with EX stalled, hold, then in-order drain
        cycle(1'b1, 32'h00509093, 32'h200, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'hFE000EE3, 32'h204, 1'b0, 1'b0, 1'b0);
        check("two_in_ready", 32'(in_ready), 32'd0);
        check("two_out_valid", 32'(out_valid), 32'd1);
        cycle(1'b1, 32'h00000013, 32'h208, 1'b0, 1'b0, 1'b0);
        check("hold_imm", out_imm, 32'h5);
        check("hold_ext_op", 32'(out_ext_op), 32'(SH));
        check("hold_pc", out_pc, 32'h200);
        idle(1'b1);
        check("drain2_imm", out_imm, 32'hFFFFFFFC);
        check("drain2_ext_op", 32'(out_ext_op), 32'(BT));
        check("drain2_in_ready", 32'(in_ready), 32'd1);
        idle(1'b1);
        check("drain_empty", 32'(out_valid), 32'd0);

        // Flush while full with a push offered; next push must be accepted
        cycle(1'b1, 32'h00100093, 32'h300, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h00200093, 32'h304, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h00300093, 32'h308, 1'b0, 1'b1, 1'b0);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_in_ready", 32'(in_ready), 32'd1);
        cycle(1'b1, 32'h00400093, 32'h30C, 1'b1, 1'b0, 1'b0);
        check("post_flush_pc", out_pc, 32'h30C);
        check("post_flush_imm", out_imm, 32'h4);
        idle(1'b1);

        // Steady push & pop in ONE: one output per cycle, in order
        cycle(1'b1, vecs[0].instr, 32'h400, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b1, vecs[i].instr, 32'h400 + 32'(4 * i), 1'b1, 1'b0, 1'b0);
            check("stream_pc", out_pc, 32'h400 + 32'(4 * i));
            check("stream_imm", out_imm, vecs[i].imm);
            check("stream_valid", 32'(out_valid), 32'd1);
            check("stream_in_ready", 32'(in_ready), 32'd1);
        end
        idle(1'b1);

        // Reset mid-transfer discards everything
        cycle(1'b1, 32'h00100093, 32'h500, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h00200093, 32'h504, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h00300093, 32'h508, 1'b1, 1'b0, 1'b1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_imm", out_imm, 32'd0);
        idle(1'b1);
        check("midrst_quiet", 32'(out_valid), 32'd0);

        // Randomized traffic against the reference model
        for (int n = 0; n < 600; n++) begin
            r32 = $urandom();
            if ($urandom_range(7) == 0) instr = $urandom();
            else instr = {r32[31:7], ops[$urandom_range(12)]};
            cycle(1'($urandom_range(3) != 0), instr, $urandom(),
                  1'($urandom_range(2) != 0), 1'($urandom_range(31) == 0),
                  1'($urandom_range(99) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
